// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port data memory arbiter.
//   DW_DEFAULT / AW_DEFAULT : default data and address widths
//   state_t                 : arbiter FSM state encoding (IDLE is all-zero so
//                             a freshly reset debug output reads 0)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin picker, purely combinational.
//   valid0, valid1 : requesters present
//   last_grant     : index of the port that was served most recently
//   grant[1:0]     : one-hot grant (all zero when nobody is valid)
// A lone requester always wins; on a tie the port that was not served last
// wins, so neither port can be starved by the other.
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = valid0 & (~valid1 | last_grant);
        grant[1] = valid1 & (~valid0 | ~last_grant);
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares one data memory between two requesters (port 0: CPU load/store,
// port 1: debug/DMA). One access at a time: IDLE -> ACCESS -> RESP -> IDLE.
//
// Ports
//   clk, reset                 : single clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata: request from port N (N = 0, 1)
//   reqN_ready                 : request accepted this cycle
//   reqN_rvalid / reqN_rdata   : one-cycle completion pulse and read data
//   mem_Address/Write_data     : latched address / write data to memory
//   mem_MemWrite/MemRead       : memory strobes, only active in ACCESS
//   mem_Read_data              : combinational memory read data
//   dbg_state                  : current FSM state, for observation only
//
// Handshake: a request transfers on a posedge where reqN_valid & reqN_ready
// are both 1. ready depends combinationally on valid, the state and the
// round-robin pointer, and at most one ready is high per cycle. Once a
// request transfers, its fields are held internally, so the requester may
// change or drop its inputs from the next cycle on. Completion is signalled
// by a single-cycle reqN_rvalid two cycles after the handshake.
// -----------------------------------------------------------------------------
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,

    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,

    output logic [AW-1:0] mem_Address,
    output logic [DW-1:0] mem_Write_data,
    output logic          mem_MemWrite,
    output logic          mem_MemRead,
    input  logic [DW-1:0] mem_Read_data,

    output state_t        dbg_state
);

    state_t        state;
    logic          last_grant;
    logic          owner;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    logic [1:0]    grant;
    logic [1:0]    ready;

    rr_pick2 u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // grant already implies valid, so ready doubles as the handshake.
    assign ready      = (state == IDLE) ? grant : 2'b00;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|ready) begin
                        owner   <= ready[1];
                        wr_q    <= ready[1] ? req1_write : req0_write;
                        addr_q  <= ready[1] ? req1_addr  : req0_addr;
                        wdata_q <= ready[1] ? req1_wdata : req0_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes leave rdata untouched so the last read value stays.
                    if (!wr_q) begin
                        rdata_q <= mem_Read_data;
                    end
                    state <= RESP;
                end
                RESP: begin
                    // Pointer moves only after the access retires.
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Address/data hold their latched values; only the strobes are gated,
    // which is what lets a write in ACCESS land even if reset is sampled
    // at the same edge.
    assign mem_Address    = addr_q;
    assign mem_Write_data = wdata_q;
    assign mem_MemWrite   = (state == ACCESS) &  wr_q;
    assign mem_MemRead    = (state == ACCESS) & ~wr_q;

    assign req0_rvalid = (state == RESP) & ~owner;
    assign req1_rvalid = (state == RESP) &  owner;
    assign req0_rdata  = rdata_q;
    assign req1_rdata  = rdata_q;

    assign dbg_state = state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with a behavioural memory, a cycle
// model of arbitration/latency, and a completion scoreboard.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic          req0_valid, req0_write, req0_ready, req0_rvalid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_write, req1_ready, req1_rvalid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic [AW-1:0] mem_Address;
    logic [DW-1:0] mem_Write_data;
    logic          mem_MemWrite, mem_MemRead;
    logic [DW-1:0] mem_Read_data;
    state_t        dbg_state;

    data_mem_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_write     (req0_write),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req0_ready     (req0_ready),
        .req0_rvalid    (req0_rvalid),
        .req0_rdata     (req0_rdata),
        .req1_valid     (req1_valid),
        .req1_write     (req1_write),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .req1_ready     (req1_ready),
        .req1_rvalid    (req1_rvalid),
        .req1_rdata     (req1_rdata),
        .mem_Address    (mem_Address),
        .mem_Write_data (mem_Write_data),
        .mem_MemWrite   (mem_MemWrite),
        .mem_MemRead    (mem_MemRead),
        .mem_Read_data  (mem_Read_data),
        .dbg_state      (dbg_state)
    );

    // ---------------- behavioural memory (256 words) ----------------
    bit [DW-1:0] mem_arr [256];
    bit          written [256];

    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        return 32'hA500_0000 | {16'h0000, a, ~a};
    endfunction

    always @(posedge clk) begin
        if (mem_MemWrite) begin
            mem_arr[mem_Address[7:0]] <= mem_Write_data;
            written[mem_Address[7:0]] <= 1'b1;
        end
    end

    always_comb begin
        mem_Read_data = '0;
        if (mem_MemRead) begin
            mem_Read_data = written[mem_Address[7:0]] ? mem_arr[mem_Address[7:0]]
                                                      : init_val(mem_Address[7:0]);
        end
    end

    // ---------------- counters and checker ----------------
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- model state and scoreboard ----------------
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] last_rd;
    logic          lg_m;
    int            busy;
    int            hs_port;
    logic          acc_pending, acc_w;
    logic [AW-1:0] acc_a;
    logic [DW-1:0] acc_d;

    logic [DW-1:0] exp_q[$];
    int            exp_port_q[$];
    int            exp_cyc_q[$];
    logic          mon_en = 1'b0;

    // Completion monitor: rvalid must appear exactly two cycles after the
    // handshake, on the owning port only, and nowhere else.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_cyc_q.size() > 0 && cyc == exp_cyc_q[0] + 2) begin
                logic [DW-1:0] d;
                int p;
                int c;
                d = exp_q.pop_front();
                p = exp_port_q.pop_front();
                c = exp_cyc_q.pop_front();
                if (p == 0) begin
                    chk("rvalid0_hit", {63'd0, req0_rvalid}, 64'd1);
                    chk("rvalid1_quiet", {63'd0, req1_rvalid}, 64'd0);
                    chk("rdata0", {32'd0, req0_rdata}, {32'd0, d});
                end else begin
                    chk("rvalid1_hit", {63'd0, req1_rvalid}, 64'd1);
                    chk("rvalid0_quiet", {63'd0, req0_rvalid}, 64'd0);
                    chk("rdata1", {32'd0, req1_rdata}, {32'd0, d});
                end
            end else begin
                chk("no_rvalid0", {63'd0, req0_rvalid}, 64'd0);
                chk("no_rvalid1", {63'd0, req1_rvalid}, 64'd0);
            end
        end
    end

    // One cycle of driving/checking. Called at a negedge with inputs for this
    // cycle already applied; returns at the next negedge.
    task automatic step();
        logic e0, e1;
        int   p;
        logic w;
        logic [AW-1:0] a;
        logic [DW-1:0] d, d_exp;
        #1;
        if (acc_pending) begin
            chk("acc_memwrite", {63'd0, mem_MemWrite}, {63'd0, acc_w});
            chk("acc_memread", {63'd0, mem_MemRead}, {63'd0, ~acc_w});
            chk("acc_addr", {32'd0, mem_Address}, {32'd0, acc_a});
            if (acc_w) chk("acc_wdata", {32'd0, mem_Write_data}, {32'd0, acc_d});
            acc_pending = 1'b0;
        end else begin
            chk("idle_memwrite", {63'd0, mem_MemWrite}, 64'd0);
            chk("idle_memread", {63'd0, mem_MemRead}, 64'd0);
        end
        e0 = (busy == 0) && req0_valid && (!req1_valid || lg_m);
        e1 = (busy == 0) && req1_valid && (!req0_valid || !lg_m);
        chk("ready0", {63'd0, req0_ready}, {63'd0, e0});
        chk("ready1", {63'd0, req1_ready}, {63'd0, e1});
        hs_port = -1;
        if (e0 || e1) begin
            p = e1 ? 1 : 0;
            w = e1 ? req1_write : req0_write;
            a = e1 ? req1_addr  : req0_addr;
            d = e1 ? req1_wdata : req0_wdata;
            if (w) begin
                model_mem[a[7:0]] = d;
                d_exp = last_rd;
            end else begin
                d_exp   = model_mem[a[7:0]];
                last_rd = d_exp;
            end
            exp_q.push_back(d_exp);
            exp_port_q.push_back(p);
            exp_cyc_q.push_back(cyc);
            acc_pending = 1'b1;
            acc_w = w;
            acc_a = a;
            acc_d = d;
            busy  = 2;
            lg_m  = p[0];
            hs_port = p;
        end else if (busy > 0) begin
            busy--;
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, {32'd0, mem_Address}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, mem_Write_data}, 64'd0);
        chk({tag, "_memwrite"}, {63'd0, mem_MemWrite}, 64'd0);
        chk({tag, "_memread"}, {63'd0, mem_MemRead}, 64'd0);
        chk({tag, "_rvalid0"}, {63'd0, req0_rvalid}, 64'd0);
        chk({tag, "_rvalid1"}, {63'd0, req1_rvalid}, 64'd0);
        chk({tag, "_rdata0"}, {32'd0, req0_rdata}, 64'd0);
        chk({tag, "_rdata1"}, {32'd0, req1_rdata}, 64'd0);
        chk({tag, "_state"}, {62'd0, dbg_state}, {62'd0, IDLE});
    endtask

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int first_hs;
        int p1_first;
        int n;

        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i[7:0]);
        last_rd = '0; lg_m = 1'b1; busy = 0; hs_port = -1;
        acc_pending = 1'b0; acc_w = 1'b0; acc_a = '0; acc_d = '0;
        reset = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("reset");
        chk("reset_ready0", {63'd0, req0_ready}, 64'd0);
        chk("reset_ready1", {63'd0, req1_ready}, 64'd0);
        mon_en = 1'b1;
        @(negedge clk);

        // Idle after reset: no strobes, no completions.
        repeat (5) step();

        // Tie from reset: port 0 first, then alternation while both held.
        req0_valid = 1; req0_write = 0; req0_addr = 32'h04;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h08;
        first_hs = -1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (hs_port >= 0 && first_hs < 0) first_hs = hs_port;
        end
        chk("tie_first_port", 64'(first_hs), 64'd0);
        req0_valid = 0; req1_valid = 0;
        repeat (3) step();

        // Port 0 write then read back.
        req0_valid = 1; req0_write = 1; req0_addr = 32'h10; req0_wdata = 32'hDEADBEEF;
        step();
        req0_valid = 0;
        repeat (3) step();
        req0_valid = 1; req0_write = 0; req0_addr = 32'h10;
        step();
        req0_valid = 0;
        repeat (3) step();

        // Address changed right after handshake must not reach memory.
        req0_valid = 1; req0_write = 0; req0_addr = 32'h20;
        step();
        req0_valid = 0; req0_addr = 32'h30;
        repeat (3) step();

        // Port 0 back-to-back while port 1 waits.
        req0_valid = 1; req0_write = 0; req0_addr = 32'h50;
        step();
        req1_valid = 1; req1_write = 0; req1_addr = 32'h0C;
        p1_first = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (hs_port == 0) req0_addr = req0_addr + 32'h1;
            if (hs_port == 1 && p1_first < 0) p1_first = i + 1;
        end
        chk("p1_granted", {63'd0, p1_first > 0 && p1_first <= 6}, 64'd1);
        req0_valid = 0; req1_valid = 0;
        repeat (3) step();

        // Reset during ACCESS of a port 1 write.
        req1_valid = 1; req1_write = 1; req1_addr = 32'h40; req1_wdata = 32'h55;
        step();
        req1_valid = 0;
        reset = 1'b1;
        exp_q.delete(); exp_port_q.delete(); exp_cyc_q.delete();
        step();
        reset = 1'b0;
        busy = 0; lg_m = 1'b1; last_rd = '0;
        #1;
        check_all_zero("post_reset");
        chk("mem_0x40", {32'd0, mem_arr[8'h40]}, 64'h55);

        // Read back the write that landed during reset.
        req0_valid = 1; req0_write = 0; req0_addr = 32'h40;
        step();
        req0_valid = 0;

        n = 0;
        while ((exp_q.size() > 0 || busy > 0) && n < 10) begin
            step();
            n++;
        end
        chk("drain", {63'd0, exp_q.size() == 0}, 64'd1);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DW, 32, data width of memory words and request write/read data.
REQ-002 Parameter AW, 32, address width of requests and of mem_Address.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req0_valid  input  1  port 0 (CPU load/store) request present.
REQ-006 req0_write  input  1  port 0 operation: 1 = write, 0 = read.
REQ-007 req0_addr  input  AW  port 0 word address.
REQ-008 req0_wdata  input  DW  port 0 write data.
REQ-009 req0_ready  output  1  port 0 request accepted this cycle.
REQ-010 req0_rvalid  output  1  one-cycle completion pulse for port 0, for reads and writes.
REQ-011 req0_rdata  output  DW  port 0 read data, valid while req0_rvalid=1.
REQ-012 req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata  same directions/widths/meanings as port 0, for port 1 (debug/DMA).
REQ-013 mem_Address  output  AW  address to data memory.
REQ-014 mem_Write_data  output  DW  write data to data memory.
REQ-015 mem_MemWrite  output  1  memory write enable; memory writes on posedge clk.
REQ-016 mem_MemRead  output  1  memory read enable.
REQ-017 mem_Read_data  input  DW  combinational read data from memory, valid while mem_MemRead=1.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on any accepted request; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-019 In IDLE, reqN_ready is a combinational function of reqN_valid, state and the round-robin pointer; a handshake is reqN_valid & reqN_ready.
REQ-020 At most one reqN_ready is high per cycle; both ready outputs are 0 outside IDLE.
REQ-021 When only one port is valid in IDLE, that port is granted.
REQ-022 When both ports are valid, the port other than last_grant is granted; last_grant is 1 after reset, so port 0 wins the first tie.
REQ-023 On handshake, the arbiter latches owner, write, addr and wdata into internal registers; later changes on the request inputs have no effect.
REQ-024 In ACCESS, mem_Address and mem_Write_data are driven from the latched registers; mem_MemWrite = latched write; mem_MemRead = ~latched write.
REQ-025 Outside ACCESS, mem_MemWrite=0 and mem_MemRead=0; mem_Address and mem_Write_data hold their last latched values.
REQ-026 A read captures mem_Read_data into the rdata register at the posedge ending ACCESS.
REQ-027 In RESP, reqN_rvalid=1 for the owning port only, for exactly one cycle; last_grant is updated to the owner at the posedge ending RESP.
REQ-028 reqN_rdata shows the rdata register; it is meaningful only while reqN_rvalid=1, and a write completion leaves the rdata register unchanged.
REQ-029 Latency: handshake at cycle T, memory access at T+1, rvalid at T+2, next handshake possible at T+3.
REQ-030 Throughput is at most one access per 3 cycles; a waiting valid port is granted no later than the next IDLE after the other port's access (no starvation).
REQ-031 Addresses pass through unmodified at the full AW bits; word indexing and truncation are the memory's concern.

Reset
REQ-032 At a posedge with reset=1, the following are cleared: state=IDLE, last_grant=1, and all latched registers and rdata = 0.
REQ-033 Every output is 0 in the cycle after reset is sampled, except reqN_ready, which follows REQ-019 from IDLE.
REQ-034 Reset sampled during ACCESS: a write in that ACCESS cycle still reaches memory at that same edge; no rvalid is issued.
REQ-035 Reset sampled during RESP cancels the rvalid pulse from the next cycle onward.

Structure
REQ-036 Shared package mem_arb_pkg holds the FSM state enum {IDLE, ACCESS, RESP} and the DW/AW default constants.
REQ-037 Round-robin selection lives in one sub-module rr_pick2 (inputs: two valids, last_grant; outputs: one-hot grant); the rest is flat.

Verification
REQ-038 Port 0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> mem_MemWrite=1 for one cycle; the read returns req0_rdata=0xDEADBEEF with req0_rvalid two cycles after the handshake.
REQ-039 Both ports valid from reset: port 0 reads 0x04, port 1 reads 0x08 -> port 0 granted first, port 1 granted 3 cycles later; alternation continues while both are held valid.
REQ-040 Port 1 is held valid for 10 cycles while port 0 issues back-to-back requests -> port 1 is granted within 6 cycles; grants never overlap.
REQ-041 Port 0 changes req0_addr from 0x20 to 0x30 in the cycle after its handshake -> the memory sees 0x20 only.
REQ-042 Reset is asserted during the ACCESS cycle of a port 1 write of 0x55 to 0x40 -> memory[0x40]=0x55, no req1_rvalid, all outputs 0 next cycle.
REQ-043 Both ports idle for 5 cycles after reset -> mem_MemRead=mem_MemWrite=0 throughout, no rvalid pulses.
